ex_stage: RTL and testbench

Execute stage of the five-stage RV32I pipeline: the ID/EX pipeline register, operand forwarding muxes, the 32-bit ALU driven by the 3-bit ALU control code from the ALU decoder, branch/jump resolution, and the EX/MEM pipeline register. It sits directly downstream of the decode stage and ALU decoder and feeds the memory stage and hazard unit.

---
 rtl/ex_stage_pkg.sv | 59 +++++
 rtl/ex_stage_alu.sv | 33 +++
 rtl/ex_stage.sv | 118 +++++++++++
 tb/tb_ex_stage.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/ex_stage_pkg.sv
// Shared encodings for the RV32I execute stage and the ALU decoder, plus
// the pipeline-register layouts used by ex_stage.
package ex_stage_pkg;
  localparam int XLEN = 32;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RS_ALU = 2'b00;
  localparam logic [1:0] RS_MEM = 2'b01;
  localparam logic [1:0] RS_PC4 = 2'b10;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef struct packed {
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            regwrite;
    logic            memwrite;
    logic            jump;
    logic            branch;
    logic            alusrc;
    logic [1:0]      resultsrc;
    logic [2:0]      aluctl;
  } idex_t;

  typedef struct packed {
    logic            regwrite;
    logic [1:0]      resultsrc;
    logic            memwrite;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] write_data;
    logic [4:0]      rd;
    logic [XLEN-1:0] pc4;
  } exmem_t;

  // Select 11 is unused and falls back to the register-file operand.
  function automatic logic [XLEN-1:0] fwd_mux(input logic [1:0] sel,
                                               input logic [XLEN-1:0] rf,
                                               input logic [XLEN-1:0] w,
                                               input logic [XLEN-1:0] m);
    case (sel)
      FWD_W:   fwd_mux = w;
      FWD_M:   fwd_mux = m;
      default: fwd_mux = rf;
    endcase
  endfunction
endpackage

// File: rtl/ex_stage_alu.sv
// 32-bit combinational ALU: add, sub, and, or, signed set-less-than.
module alu
  import ex_stage_pkg::*;
(
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic [2:0]      ALUControl,
  output logic [XLEN-1:0] ALUResult,
  output logic            Zero
);
  logic [XLEN-1:0] w_diff;
  logic            w_ovf;
  logic            w_lt;

  assign w_diff = SrcA - SrcB;
  // Signed less-than is N xor V of the subtraction, so it holds across overflow.
  assign w_ovf  = (SrcA[XLEN-1] ^ SrcB[XLEN-1]) & (w_diff[XLEN-1] ^ SrcA[XLEN-1]);
  assign w_lt   = w_diff[XLEN-1] ^ w_ovf;

  always_comb begin
    ALUResult = '0;
    case (ALUControl)
      ALU_ADD: ALUResult = SrcA + SrcB;
      ALU_SUB: ALUResult = w_diff;
      ALU_AND: ALUResult = SrcA & SrcB;
      ALU_OR:  ALUResult = SrcA | SrcB;
      ALU_SLT: ALUResult = {{(XLEN-1){1'b0}}, w_lt};
      default: ALUResult = '0;
    endcase
  end

  assign Zero = (ALUResult == '0);
endmodule

// File: rtl/ex_stage.sv
// Execute stage: ID/EX register, operand forwarding, ALU, branch resolution
// and the EX/MEM register.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            FlushE,
  input  logic [XLEN-1:0] RD1D,
  input  logic [XLEN-1:0] RD2D,
  input  logic [XLEN-1:0] ImmExtD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic [4:0]      Rs1D,
  input  logic [4:0]      Rs2D,
  input  logic [4:0]      RdD,
  input  logic            RegWriteD,
  input  logic            MemWriteD,
  input  logic            JumpD,
  input  logic            BranchD,
  input  logic            ALUSrcD,
  input  logic [1:0]      ResultSrcD,
  input  logic [2:0]      ALUControlD,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic            ResultSrcE0,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic [1:0]      ResultSrcM,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [4:0]      RdM
);
  idex_t           r_e;
  exmem_t          r_m;
  idex_t           w_d;
  exmem_t          w_m_next;
  logic [XLEN-1:0] w_srca;
  logic [XLEN-1:0] w_wdata;
  logic [XLEN-1:0] w_srcb;
  logic [XLEN-1:0] w_alu_res;
  logic            w_zero;

  always_comb begin
    w_d           = '0;
    w_d.rd1       = RD1D;
    w_d.rd2       = RD2D;
    w_d.imm       = ImmExtD;
    w_d.pc        = PCD;
    w_d.pc4       = PCPlus4D;
    w_d.rs1       = Rs1D;
    w_d.rs2       = Rs2D;
    w_d.rd        = RdD;
    w_d.regwrite  = RegWriteD;
    w_d.memwrite  = MemWriteD;
    w_d.jump      = JumpD;
    w_d.branch    = BranchD;
    w_d.alusrc    = ALUSrcD;
    w_d.resultsrc = ResultSrcD;
    w_d.aluctl    = ALUControlD;
  end

  // A flush loads an all-zero bubble: no write, no branch, no jump.
  always_ff @(posedge clk) begin
    if (reset || FlushE) r_e <= '0;
    else                 r_e <= w_d;
  end

  assign w_srca  = fwd_mux(ForwardAE, r_e.rd1, ResultW, r_m.alu_result);
  assign w_wdata = fwd_mux(ForwardBE, r_e.rd2, ResultW, r_m.alu_result);
  assign w_srcb  = r_e.alusrc ? r_e.imm : w_wdata;

  alu u_alu (
    .SrcA       (w_srca),
    .SrcB       (w_srcb),
    .ALUControl (r_e.aluctl),
    .ALUResult  (w_alu_res),
    .Zero       (w_zero)
  );

  assign PCSrcE      = (r_e.branch & w_zero) | r_e.jump;
  assign PCTargetE   = r_e.pc + r_e.imm;
  assign Rs1E        = r_e.rs1;
  assign Rs2E        = r_e.rs2;
  assign RdE         = r_e.rd;
  assign ResultSrcE0 = r_e.resultsrc[0];

  always_comb begin
    w_m_next            = '0;
    w_m_next.regwrite   = r_e.regwrite;
    w_m_next.resultsrc  = r_e.resultsrc;
    w_m_next.memwrite   = r_e.memwrite;
    w_m_next.alu_result = w_alu_res;
    w_m_next.write_data = w_wdata;
    w_m_next.rd         = r_e.rd;
    w_m_next.pc4        = r_e.pc4;
  end

  always_ff @(posedge clk) begin
    if (reset) r_m <= '0;
    else       r_m <= w_m_next;
  end

  assign RegWriteM  = r_m.regwrite;
  assign MemWriteM  = r_m.memwrite;
  assign ResultSrcM = r_m.resultsrc;
  assign ALUResultM = r_m.alu_result;
  assign WriteDataM = r_m.write_data;
  assign PCPlus4M   = r_m.pc4;
  assign RdM        = r_m.rd;
endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed literal cases plus randomized
// traffic compared every cycle against an instruction-level model.
module tb_ex_stage;
  logic        clk = 1'b0;
  logic        reset, FlushE;
  logic [31:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D, ResultW;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic        RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
  logic [1:0]  ResultSrcD, ForwardAE, ForwardBE;
  logic [2:0]  ALUControlD;
  logic [4:0]  Rs1E, Rs2E, RdE, RdM;
  logic        ResultSrcE0, PCSrcE, RegWriteM, MemWriteM;
  logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
  logic [1:0]  ResultSrcM;

  ex_stage dut (
    .clk(clk), .reset(reset), .FlushE(FlushE),
    .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
    .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ResultSrcE0(ResultSrcE0),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RdM(RdM)
  );

  always #5 clk = ~clk;

  // Model view: the instruction currently in execute and the one in memory.
  typedef struct {
    logic [31:0] a, b, imm, pc, pc4;
    logic [4:0]  rs1, rs2, rd;
    logic        rw, mw, j, br, src;
    logic [1:0]  rs;
    logic [2:0]  op;
  } ins_t;
  typedef struct {
    logic        rw, mw;
    logic [1:0]  rs;
    logic [31:0] res, wd, pc4;
    logic [4:0]  rd;
  } mem_t;

  ins_t ins_e, bubble;
  mem_t ins_m, mem_zero;
  int   checks = 0, errors = 0;
  bit   chk_on = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [31:0] x, input logic [31:0] y,
                                          input logic [2:0] op);
    case (op)
      3'd0: return x + y;
      3'd1: return x - y;
      3'd2: return x & y;
      3'd3: return x | y;
      3'd5: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] rf);
    if (s == 2'd1) return ResultW;
    if (s == 2'd2) return ins_m.res;
    return rf;
  endfunction

  function automatic logic [31:0] op_a();
    return pick(ForwardAE, ins_e.a);
  endfunction
  function automatic logic [31:0] op_wd();
    return pick(ForwardBE, ins_e.b);
  endfunction
  function automatic logic [31:0] exe_res();
    logic [31:0] wd;
    wd = op_wd();
    return alu_ref(op_a(), ins_e.src ? ins_e.imm : wd, ins_e.op);
  endfunction

  // Advance the model and DUT by one edge, then leave a margin before new stimulus.
  task automatic step();
    mem_t nm;
    ins_t ne;
    @(posedge clk);
    nm.rw = ins_e.rw; nm.mw = ins_e.mw; nm.rs = ins_e.rs;
    nm.res = exe_res(); nm.wd = op_wd(); nm.pc4 = ins_e.pc4; nm.rd = ins_e.rd;
    ne.a = RD1D; ne.b = RD2D; ne.imm = ImmExtD; ne.pc = PCD; ne.pc4 = PCPlus4D;
    ne.rs1 = Rs1D; ne.rs2 = Rs2D; ne.rd = RdD; ne.rw = RegWriteD; ne.mw = MemWriteD;
    ne.j = JumpD; ne.br = BranchD; ne.src = ALUSrcD; ne.rs = ResultSrcD; ne.op = ALUControlD;
    ins_m = reset ? mem_zero : nm;
    ins_e = (reset || FlushE) ? bubble : ne;
    #2;
  endtask

  task automatic nop();
    reset = 0; FlushE = 0; RD1D = 0; RD2D = 0; ImmExtD = 0; PCD = 0; PCPlus4D = 0;
    Rs1D = 0; Rs2D = 0; RdD = 0; RegWriteD = 0; MemWriteD = 0; JumpD = 0; BranchD = 0;
    ALUSrcD = 0; ResultSrcD = 0; ALUControlD = 0; ForwardAE = 0; ForwardBE = 0; ResultW = 0;
  endtask

  task automatic rand_in();
    RD1D = $urandom; RD2D = $urandom; PCD = $urandom; PCPlus4D = PCD + 32'd4;
    ImmExtD = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
    if ($urandom_range(0, 3) == 0) RD2D = RD1D;  // drive equal operands so beq fires
    Rs1D = 5'($urandom); Rs2D = 5'($urandom); RdD = 5'($urandom);
    RegWriteD = 1'($urandom); MemWriteD = 1'($urandom); JumpD = ($urandom_range(0, 5) == 0);
    BranchD = 1'($urandom); ALUSrcD = 1'($urandom); ResultSrcD = 2'($urandom_range(0, 2));
    ALUControlD = 3'($urandom); ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
    ResultW = ($urandom_range(0, 3) == 0) ? RD1D : $urandom;
    FlushE = ($urandom_range(0, 7) == 0);
    reset = ($urandom_range(0, 39) == 0);
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      logic [31:0] r;
      r = exe_res();
      chk("Rs1E", 32'(Rs1E), 32'(ins_e.rs1));
      chk("Rs2E", 32'(Rs2E), 32'(ins_e.rs2));
      chk("RdE", 32'(RdE), 32'(ins_e.rd));
      chk("ResultSrcE0", 32'(ResultSrcE0), 32'(ins_e.rs[0]));
      chk("PCSrcE", 32'(PCSrcE), 32'((ins_e.br && r == 0) || ins_e.j));
      chk("PCTargetE", PCTargetE, ins_e.pc + ins_e.imm);
      chk("RegWriteM", 32'(RegWriteM), 32'(ins_m.rw));
      chk("MemWriteM", 32'(MemWriteM), 32'(ins_m.mw));
      chk("ResultSrcM", 32'(ResultSrcM), 32'(ins_m.rs));
      chk("ALUResultM", ALUResultM, ins_m.res);
      chk("WriteDataM", WriteDataM, ins_m.wd);
      chk("PCPlus4M", PCPlus4M, ins_m.pc4);
      chk("RdM", 32'(RdM), 32'(ins_m.rd));
    end
  end

  initial begin
    bubble = '{default: '0};
    mem_zero = '{default: '0};
    ins_e = bubble; ins_m = mem_zero;
    nop();
    // Reset with busy inputs.
    rand_in(); reset = 1; FlushE = 0;
    step(); step();
    chk_on = 1;
    chk("rst_PCSrcE", 32'(PCSrcE), 0);
    chk("rst_PCTargetE", PCTargetE, 0);
    chk("rst_RegWriteM", 32'(RegWriteM), 0);
    chk("rst_ALUResultM", ALUResultM, 0);
    chk("rst_RdE", 32'(RdE), 0);
    chk("rst_PCPlus4M", PCPlus4M, 0);

    // add then sub
    nop(); RD1D = 7; RD2D = 5; ALUControlD = 3'b000; step();
    ALUControlD = 3'b001; step();
    chk("add_res", ALUResultM, 32'd12);
    nop(); step();
    chk("sub_res", ALUResultM, 32'd2);

    // slt across signed overflow
    RD1D = 32'h8000_0000; RD2D = 1; ALUControlD = 3'b101; step();
    RD1D = 32'h7FFF_FFFF; RD2D = 32'hFFFF_FFFF; step();
    chk("slt_min_lt_1", ALUResultM, 32'd1);
    nop(); step();
    chk("slt_max_vs_m1", ALUResultM, 32'd0);

    // Forwarding from M and W
    RD1D = 32'h100; step();
    RD1D = 32'hDEAD; RD2D = 32'hBEEF; step();
    chk("fwd_setup_m", ALUResultM, 32'h100);
    nop(); ForwardAE = 2'b10; ForwardBE = 2'b01; ResultW = 32'h20; step();
    chk("fwd_alu", ALUResultM, 32'h120);
    chk("fwd_wdata", WriteDataM, 32'h20);
    nop();

    // Branch taken / not taken
    BranchD = 1; RD1D = 9; RD2D = 9; PCD = 32'h40; ImmExtD = 32'hFFFF_FFF8; ALUControlD = 3'b001;
    step();
    chk("br_taken", 32'(PCSrcE), 1);
    chk("br_target", PCTargetE, 32'h38);
    RD2D = 8; step();
    chk("br_not_taken", 32'(PCSrcE), 0);

    // Flush with write/jump bits set
    nop(); FlushE = 1; RegWriteD = 1; MemWriteD = 1; JumpD = 1; step();
    chk("flush_pcsrc", 32'(PCSrcE), 0);
    nop(); step();
    chk("flush_regw", 32'(RegWriteM), 0);
    chk("flush_memw", 32'(MemWriteM), 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_in();
      step();
    end
    nop(); step(); step();
    @(negedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
